// File: rtl/myproject_layernorm_stats.sv
// Row statistics for layernorm: accumulates a row, derives mean/variance, looks up an
// inverse-std scale, then streams mean-centred samples. Saturation option: MYPROJECT_LN_CENTER_SAT_EN.
//
// state  | meaning
// S_ACC  | accepting samples into the row buffer, accumulating sum and sum of squares
// S_MEAN | mean = sum >>> log2(N)
// S_VAR  | var = E[x^2] - mean^2, clamped at 0
// S_LUT  | scale lookup, first output loaded
// S_EMIT | streaming centred samples with the row scale
module myproject_layernorm_stats #(
    parameter int N         = 8,
    parameter int DATA_W    = 14,
    parameter int SCALE_W   = 8,
    parameter int VAR_SHIFT = 4
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic signed [DATA_W-1:0]  in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [DATA_W-1:0]  out_data,
    output logic [SCALE_W-1:0]        out_scale,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int LOG2N = $clog2(N);
    localparam int CNT_W = LOG2N;
    localparam int SUM_W = DATA_W + LOG2N;
    localparam int SQ_W  = 2 * DATA_W - 1 + LOG2N;
    localparam int VW    = SQ_W + 1;
    localparam int PW    = 2 * DATA_W;

    typedef enum logic [2:0] {S_ACC, S_MEAN, S_VAR, S_LUT, S_EMIT} state_t;

    // ROM[k] = floor(sqrt(65536 / (k+1))), clamped to 255
    function automatic logic [SCALE_W-1:0] rom_val(input int k);
        int r;
        r = 0;
        for (int v = 0; v <= 256; v++) begin
            if (v * v * (k + 1) <= 65536) r = v;
        end
        if (r > 255) r = 255;
        return SCALE_W'(r);
    endfunction

    function automatic logic signed [DATA_W-1:0] center(input logic signed [DATA_W-1:0] x,
                                                         input logic signed [DATA_W-1:0] m);
`ifdef MYPROJECT_LN_CENTER_SAT_EN
        logic signed [DATA_W:0] d;
        d = (DATA_W+1)'(x) - (DATA_W+1)'(m);
        if (d[DATA_W] != d[DATA_W-1])
            return d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return d[DATA_W-1:0];
`else
        return x - m;
`endif
    endfunction

    logic [SCALE_W-1:0] rom [256];
    for (genvar k = 0; k < 256; k++) begin : g_rom
        assign rom[k] = rom_val(k);
    end

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_nx;
    logic signed [SUM_W-1:0]    sum_q, sum_d, sum_sh;
    logic [SQ_W-1:0]            sumsq_q, sumsq_d;
    logic signed [DATA_W-1:0]   mean_q, mean_d;
    logic [SQ_W-1:0]            var_q, var_d, var_sh;
    logic signed [PW-1:0]       sq, mean_sq;
    logic signed [VW-1:0]       var_diff;
    logic [7:0]                 idx;
    logic signed [DATA_W-1:0]   out_data_q, out_data_d;
    logic [SCALE_W-1:0]         out_scale_q, out_scale_d;
    logic                       out_last_q, out_last_d;
    logic                       out_valid_q, out_valid_d;
    logic                       in_ready_q, in_ready_d;
    logic                       row_we;
    logic signed [DATA_W-1:0]   row_q [N];

    assign sq       = PW'(in_data) * PW'(in_data);
    assign sum_sh   = sum_q >>> LOG2N;
    assign mean_sq  = PW'(mean_q) * PW'(mean_q);
    assign var_diff = $signed({1'b0, sumsq_q >> LOG2N}) - VW'(mean_sq);
    assign var_sh   = var_q >> VAR_SHIFT;
    assign idx      = (|var_sh[SQ_W-1:8]) ? 8'hFF : var_sh[7:0];
    assign cnt_nx   = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        sumsq_d     = sumsq_q;
        mean_d      = mean_q;
        var_d       = var_q;
        out_data_d  = out_data_q;
        out_scale_d = out_scale_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        row_we      = 1'b0;
        case (state_q)
            S_ACC: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    row_we  = 1'b1;
                    sum_d   = sum_q + SUM_W'(in_data);
                    sumsq_d = sumsq_q + SQ_W'($unsigned(sq));
                    cnt_d   = cnt_nx;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d    = S_MEAN;
                        in_ready_d = 1'b0;
                    end
                end
            end
            S_MEAN: begin
                mean_d  = sum_sh[DATA_W-1:0];
                state_d = S_VAR;
            end
            S_VAR: begin
                var_d   = var_diff[VW-1] ? '0 : var_diff[SQ_W-1:0];
                state_d = S_LUT;
            end
            S_LUT: begin
                out_scale_d = rom[idx];
                out_data_d  = center(row_q[cnt_q], mean_q);
                out_last_d  = (cnt_q == CNT_W'(N - 1));
                out_valid_d = 1'b1;
                state_d     = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        cnt_d       = '0;
                        sum_d       = '0;
                        sumsq_d     = '0;
                        state_d     = S_ACC;
                    end else begin
                        cnt_d      = cnt_nx;
                        out_data_d = center(row_q[cnt_nx], mean_q);
                        out_last_d = (cnt_nx == CNT_W'(N - 1));
                    end
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= S_ACC;
            cnt_q       <= '0;
            sum_q       <= '0;
            sumsq_q     <= '0;
            mean_q      <= '0;
            var_q       <= '0;
            out_data_q  <= '0;
            out_scale_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            sumsq_q     <= sumsq_d;
            mean_q      <= mean_d;
            var_q       <= var_d;
            out_data_q  <= out_data_d;
            out_scale_q <= out_scale_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Row buffer needs no reset: every slot is rewritten before it is read.
    always_ff @(posedge ap_clk) begin
        if (row_we) row_q[cnt_q] <= in_data;
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_scale = out_scale_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_myproject_layernorm_stats.sv
// Randomized self-checking bench for myproject_layernorm_stats (N=8) with a row-level reference model.
module tb_myproject_layernorm_stats;
    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic signed [13:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [13:0] out_data;
    logic [7:0]         out_scale;
    logic               out_last;
    logic               out_valid;
    logic               out_ready = 1'b1;

    myproject_layernorm_stats #(.N(8), .DATA_W(14), .SCALE_W(8), .VAR_SHIFT(4)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_scale(out_scale), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int row_s [8];
    int exp_data [8];
    int exp_scale = 0;
    int exp_mean = 0;
    bit row_pending = 1'b0;
    bit first_seen = 1'b0;
    bit mon_en = 1'b0;
    bit rand_ready = 1'b0;
    int out_idx = 0;
    int acc_cyc = 0;
    int stall_at = -1;
    int stall_left = 0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rom_model(input int k);
        int v = 256;
        while (v * v * (k + 1) > 65536) v--;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int centred(input int x, input int m);
        int d = x - m;
`ifdef MYPROJECT_LN_CENTER_SAT_EN
        if (d > 8191) d = 8191;
        if (d < -8192) d = -8192;
`else
        d = ((d + 8192) & 16383) - 8192;
`endif
        return d;
    endfunction

    task automatic model_load();
        int sum = 0, sumsq = 0, var_v, k;
        for (int i = 0; i < 8; i++) begin
            sum += row_s[i];
            sumsq += row_s[i] * row_s[i];
        end
        exp_mean = sum >>> 3;
        var_v = (sumsq >> 3) - exp_mean * exp_mean;
        if (var_v < 0) var_v = 0;
        k = var_v >> 4;
        if (k > 255) k = 255;
        exp_scale = rom_model(k);
        for (int i = 0; i < 8; i++) exp_data[i] = centred(row_s[i], exp_mean);
        out_idx = 0;
        first_seen = 1'b0;
        row_pending = 1'b1;
    endtask

    // Output checker: every cycle with out_valid is compared against the model.
    always @(negedge ap_clk) begin
        if (mon_en && out_valid) begin
            if (!row_pending) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                if (!first_seen) begin
                    check("latency", cyc - acc_cyc, 4);
                    first_seen = 1'b1;
                end
                check("out_data", int'(out_data), exp_data[out_idx]);
                check("out_scale", int'(out_scale), exp_scale);
                check("out_last", int'(out_last), int'(out_idx == 7));
                check("in_ready_during_emit", int'(in_ready), 0);
                if (out_ready) begin
                    if (out_idx == 7) begin
                        row_pending = 1'b0;
                        out_idx = 0;
                    end else begin
                        out_idx++;
                    end
                end
            end
        end
    end

    always @(posedge ap_clk) begin
        #1;
        if (stall_left > 0 && out_valid && out_idx == stall_at) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic send_row(input bit gaps);
        bit skip = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit sent = 1'b0;
            int wd = 0;
            while (!sent) begin
                @(negedge ap_clk);
                if (gaps && skip) begin
                    in_valid = 1'b0;
                    skip = 1'b0;
                end else if (in_ready) begin
                    in_valid = 1'b1;
                    in_data = 14'(row_s[i]);
                    sent = 1'b1;
                    skip = gaps;
                    if (i == 7) begin
                        model_load();
                        acc_cyc = cyc;
                    end
                end else begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data = 14'($urandom);
                    wd++;
                    if (wd > 400) begin
                        check("in_ready_timeout", 0, 1);
                        in_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        @(negedge ap_clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int wd = 0;
        while (row_pending && wd < 600) begin
            @(negedge ap_clk);
            wd++;
        end
        @(negedge ap_clk);
        check("row_drain_timeout", int'(row_pending), 0);
        check("scale_holds_in_acc", int'(out_scale), exp_scale);
    endtask

    task automatic fill(input int a, input int b, input int split);
        for (int i = 0; i < 8; i++) row_s[i] = (i < split) ? a : b;
    endtask

    initial begin
        repeat (3) @(posedge ap_clk);
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_scale", int'(out_scale), 0);
        check("rst_in_ready", int'(in_ready), 0);
        ap_rst = 1'b0;
        @(posedge ap_clk);
        #2;
        check("in_ready_after_rst", int'(in_ready), 1);
        mon_en = 1'b1;

        check("rom_model_3", rom_model(3), 128);
        check("rom_model_255", rom_model(255), 16);

        fill(100, 100, 8);
        send_row(1'b0);
        check("model_s1_mean", exp_mean, 100);
        check("model_s1_scale", exp_scale, 255);
        wait_idle();

        for (int i = 0; i < 8; i++) row_s[i] = (i % 2 == 0) ? 64 : -64;
        send_row(1'b0);
        check("model_s2_scale", exp_scale, 16);
        check("model_s2_data1", exp_data[1], -64);
        wait_idle();

        fill(-1, 0, 7);
        send_row(1'b0);
        check("model_s3_mean", exp_mean, -1);
        check("model_s3_scale", exp_scale, 255);
        check("model_s3_data7", exp_data[7], 1);
        wait_idle();

        fill(-8192, 8191, 4);
        send_row(1'b0);
        check("model_s4_mean", exp_mean, -1);
        check("model_s4_scale", exp_scale, 16);
        check("model_s4_data0", exp_data[0], -8191);
`ifdef MYPROJECT_LN_CENTER_SAT_EN
        check("model_s4_data7", exp_data[7], 8191);
`else
        check("model_s4_data7", exp_data[7], -8192);
`endif
        wait_idle();

        // same row fed with in_valid toggling every other cycle
        send_row(1'b1);
        wait_idle();

        for (int i = 0; i < 8; i++) row_s[i] = $urandom_range(0, 4000) - 2000;
        stall_at = 3;
        stall_left = 5;
        send_row(1'b0);
        wait_idle();
        check("stall_applied", stall_left, 0);
        stall_at = -1;

        // reset during emission at output 4
        fill(100, 100, 8);
        send_row(1'b0);
        begin
            int wd = 0;
            do begin
                @(posedge ap_clk);
                #2;
                wd++;
            end while (!(out_valid && out_idx == 4) && wd < 100);
            check("reach_output4", int'(out_valid && out_idx == 4), 1);
        end
        ap_rst = 1'b1;
        mon_en = 1'b0;
        @(posedge ap_clk);
        #2;
        ap_rst = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready_low", int'(in_ready), 0);
        row_pending = 1'b0;
        out_idx = 0;
        @(posedge ap_clk);
        #2;
        check("midrst_in_ready_high", int'(in_ready), 1);
        mon_en = 1'b1;
        send_row(1'b0);
        check("model_s6_scale", exp_scale, 255);
        wait_idle();

        rand_ready = 1'b1;
        for (int r = 0; r < 20; r++) begin
            int amp;
            case ($urandom_range(0, 3))
                0: amp = 15;
                1: amp = 200;
                2: amp = 2000;
                default: amp = 8192;
            endcase
            for (int i = 0; i < 8; i++) begin
                int x = int'($urandom_range(0, 2 * amp)) - amp;
                if (x > 8191) x = 8191;
                row_s[i] = x;
            end
            send_row(1'($urandom_range(0, 1)));
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
